// File: rtl/ber_checker.sv
// Bit-error-rate checker placed after the Viterbi decoder.
// Keeps a history of source bits, searches for the decoder latency that lines
// the decoded stream up with the source, locks onto it, then counts compared
// bits and mismatches until the error density in a window says lock was lost.
module ber_checker #(
   parameter int MAX_LAT  = 64,
   parameter int LOCK_WIN = 32,
   parameter int WIN_LEN  = 64,
   parameter int LOSS_THR = 8,
   parameter int CNT_W    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ref_valid_i,
   input  logic                       ref_bit_i,
   input  logic                       dec_valid_i,
   input  logic                       dec_bit_i,
   input  logic                       clear_i,
   output logic                       lock_o,
   output logic [$clog2(MAX_LAT)-1:0] lat_o,
   output logic [CNT_W-1:0]           bit_cnt_o,
   output logic [CNT_W-1:0]           err_cnt_o,
   output logic                       err_pulse_o
);

   localparam int LAT_W   = $clog2(MAX_LAT);
   localparam int FILL_W  = LAT_W + 1;
   localparam int MATCH_W = $clog2(LOCK_WIN + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   logic [MAX_LAT-1:0] r_hist;
   logic [FILL_W-1:0]  r_refFill;
   logic [LAT_W-1:0]   r_lat;
   logic [MATCH_W-1:0] r_matchCnt;
   logic [WIN_W-1:0]   r_winCnt;
   logic [WIN_W-1:0]   r_winErr;
   logic [CNT_W-1:0]   r_bitCnt;
   logic [CNT_W-1:0]   r_errCnt;
   logic               r_errPulse;

   state_t             w_stateNext;
   logic [LAT_W-1:0]   w_latNext;
   logic [MATCH_W-1:0] w_matchNext;
   logic [WIN_W-1:0]   w_winCntNext;
   logic [WIN_W-1:0]   w_winErrNext;
   logic [CNT_W-1:0]   w_bitNext;
   logic [CNT_W-1:0]   w_errNext;
   logic               w_pulseNext;

   logic               w_compare;
   logic               w_mismatch;
   logic [WIN_W-1:0]   w_winCntInc;
   logic [WIN_W-1:0]   w_winErrInc;

   // A compare needs a history entry at the candidate latency; the tapped bit
   // is the one held before this edge, so a same-cycle shift never affects it.
   assign w_compare   = dec_valid_i && (r_refFill > {1'b0, r_lat});
   assign w_mismatch  = dec_bit_i ^ r_hist[r_lat];
   assign w_winCntInc = r_winCnt + 1'b1;
   assign w_winErrInc = r_winErr + WIN_W'(w_mismatch);

   // Source-bit history and saturating fill count, advanced on each ref strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist    <= '0;
         r_refFill <= '0;
      end else if (ref_valid_i) begin
         r_hist <= {r_hist[MAX_LAT-2:0], ref_bit_i};
         if (r_refFill != FILL_W'(MAX_LAT)) begin
            r_refFill <= r_refFill + 1'b1;
         end
      end
   end

   // Next-state logic: latency search, lock, window-based loss detection and
   // the saturating measurement counters with clear taking priority.
   always_comb begin
      w_stateNext  = r_state;
      w_latNext    = r_lat;
      w_matchNext  = r_matchCnt;
      w_winCntNext = r_winCnt;
      w_winErrNext = r_winErr;
      w_bitNext    = r_bitCnt;
      w_errNext    = r_errCnt;
      w_pulseNext  = 1'b0;

      case (r_state)
         SEARCH: begin
            if (w_compare) begin
               if (!w_mismatch) begin
                  if (32'(r_matchCnt) == LOCK_WIN - 1) begin
                     w_stateNext  = LOCKED;
                     w_matchNext  = '0;
                     w_winCntNext = '0;
                     w_winErrNext = '0;
                  end else begin
                     w_matchNext = r_matchCnt + 1'b1;
                  end
               end else begin
                  w_matchNext = '0;
                  w_latNext   = r_lat + 1'b1;
               end
            end
         end
         LOCKED: begin
            if (w_compare) begin
               w_bitNext = (&r_bitCnt) ? r_bitCnt : r_bitCnt + 1'b1;
               if (w_mismatch) begin
                  w_errNext   = (&r_errCnt) ? r_errCnt : r_errCnt + 1'b1;
                  w_pulseNext = 1'b1;
               end
               if (32'(w_winCntInc) == WIN_LEN) begin
                  w_winCntNext = '0;
                  w_winErrNext = '0;
                  if (32'(w_winErrInc) >= LOSS_THR) begin
                     w_stateNext = SEARCH;
                     w_latNext   = r_lat + 1'b1;
                     w_matchNext = '0;
                  end
               end else begin
                  w_winCntNext = w_winCntInc;
                  w_winErrNext = w_winErrInc;
               end
            end
         end
         default: begin
            w_stateNext = SEARCH;
         end
      endcase

      if (clear_i) begin
         w_bitNext = '0;
         w_errNext = '0;
      end
   end

   // State register for the search/lock machine and its counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= SEARCH;
         r_lat      <= '0;
         r_matchCnt <= '0;
         r_winCnt   <= '0;
         r_winErr   <= '0;
         r_bitCnt   <= '0;
         r_errCnt   <= '0;
         r_errPulse <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_lat      <= w_latNext;
         r_matchCnt <= w_matchNext;
         r_winCnt   <= w_winCntNext;
         r_winErr   <= w_winErrNext;
         r_bitCnt   <= w_bitNext;
         r_errCnt   <= w_errNext;
         r_errPulse <= w_pulseNext;
      end
   end

   assign lock_o      = (r_state == LOCKED);
   assign lat_o       = r_lat;
   assign bit_cnt_o   = r_bitCnt;
   assign err_cnt_o   = r_errCnt;
   assign err_pulse_o = r_errPulse;

endmodule

// File: tb/tb_ber_checker.sv
// Directed self-checking bench for ber_checker: a PRBS15 source feeds the
// reference port while a delayed (optionally inverted) copy feeds the decoded
// port. Expected error pulses go into a queue when an error is injected and
// are popped when the checker's pulse output is due.
module tb_ber_checker;

   logic       clk;
   logic       rst;
   logic       ref_valid_i;
   logic       ref_bit_i;
   logic       dec_valid_i;
   logic       dec_bit_i;
   logic       clear_i;

   logic        lock_o;
   logic [5:0]  lat_o;
   logic [31:0] bit_cnt_o;
   logic [31:0] err_cnt_o;
   logic        err_pulse_o;

   logic        satLock;
   logic [5:0]  satLat;
   logic [3:0]  satBit;
   logic [3:0]  satErr;
   logic        satPulse;

   int          passCount;
   int          totalCount;
   int          cycle;
   int          srcCount;
   logic [127:0] srcHist;
   logic [14:0] lfsr;
   int          expQ[$];
   bit          monEn;

   ber_checker dut (
      .clk         (clk),
      .rst         (rst),
      .ref_valid_i (ref_valid_i),
      .ref_bit_i   (ref_bit_i),
      .dec_valid_i (dec_valid_i),
      .dec_bit_i   (dec_bit_i),
      .clear_i     (clear_i),
      .lock_o      (lock_o),
      .lat_o       (lat_o),
      .bit_cnt_o   (bit_cnt_o),
      .err_cnt_o   (err_cnt_o),
      .err_pulse_o (err_pulse_o)
   );

   ber_checker #(.CNT_W(4), .LOSS_THR(65)) dutSat (
      .clk         (clk),
      .rst         (rst),
      .ref_valid_i (ref_valid_i),
      .ref_bit_i   (ref_bit_i),
      .dec_valid_i (dec_valid_i),
      .dec_bit_i   (dec_bit_i),
      .clear_i     (clear_i),
      .lock_o      (satLock),
      .lat_o       (satLat),
      .bit_cnt_o   (satBit),
      .err_cnt_o   (satErr),
      .err_pulse_o (satPulse)
   );

   // 100 MHz free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when it does not hold.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCount++;
      assert (obs === exp) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives one source bit and the decoded bit delayed by 'delay' compare
   // slots, optionally inverted, then watches the error pulse after the edge.
   task automatic applyStimulus(input int delay, input bit flip, input bit clr);
      logic newBit;
      bit   decOk;
      @(negedge clk);
      newBit = lfsr[14] ^ lfsr[13];
      lfsr   = {lfsr[13:0], newBit};
      decOk  = (srcCount >= delay + 1);
      ref_valid_i = 1'b1;
      ref_bit_i   = newBit;
      dec_valid_i = decOk;
      dec_bit_i   = decOk ? (srcHist[delay] ^ flip) : 1'b0;
      clear_i     = clr;
      if (flip && decOk && monEn) expQ.push_back(cycle + 1);
      srcHist  = {srcHist[126:0], newBit};
      srcCount++;
      @(posedge clk);
      cycle++;
      #1;
      if (monEn) begin
         if (expQ.size() > 0 && expQ[0] == cycle) begin
            void'(expQ.pop_front());
            checkOutput("pulseAt", {63'b0, err_pulse_o}, 64'd1);
         end else if (err_pulse_o !== 1'b0) begin
            checkOutput("pulseSpurious", {63'b0, err_pulse_o}, 64'd0);
         end
      end
   endtask

   // Steps the stream until lock or the cycle budget runs out.
   task automatic waitLock(input int delay, input int budget);
      int n;
      n = 0;
      while (lock_o !== 1'b1 && n < budget) begin
         applyStimulus(delay, 1'b0, 1'b0);
         n++;
      end
      checkOutput("lockReached", {63'b0, lock_o}, 64'd1);
   endtask

   // Synchronous-looking reset pulse plus restart of the bench source history.
   task automatic doReset();
      checkOutput("pulseQueueEmpty", 64'(expQ.size()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ref_valid_i = 1'b0;
      dec_valid_i = 1'b0;
      clear_i     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      srcCount = 0;
      srcHist  = '0;
      expQ.delete();
   endtask

   // Directed sequence of scenarios.
   initial begin
      passCount   = 0;
      totalCount  = 0;
      cycle       = 0;
      srcCount    = 0;
      srcHist     = '0;
      lfsr        = 15'h5A5A;
      monEn       = 1'b1;
      rst         = 1'b0;
      ref_valid_i = 1'b0;
      ref_bit_i   = 1'b0;
      dec_valid_i = 1'b0;
      dec_bit_i   = 1'b0;
      clear_i     = 1'b0;

      #23;
      checkOutput("rstLock", {63'b0, lock_o}, 64'd0);
      checkOutput("rstLat", 64'(lat_o), 64'd0);
      checkOutput("rstBit", 64'(bit_cnt_o), 64'd0);
      checkOutput("rstErr", 64'(err_cnt_o), 64'd0);
      checkOutput("rstPulse", {63'b0, err_pulse_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] decoded bits with empty history must be ignored");
      @(negedge clk);
      dec_valid_i = 1'b1;
      dec_bit_i   = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("emptyHistLat", 64'(lat_o), 64'd0);
      checkOutput("emptyHistLock", {63'b0, lock_o}, 64'd0);
      doReset();

      $display("[TB] error-free channel, latency 20");
      waitLock(20, 600);
      checkOutput("cleanLat", 64'(lat_o), 64'd20);
      for (int i = 1; i <= 1000; i++) applyStimulus(20, 1'b0, 1'b0);
      checkOutput("cleanBit", 64'(bit_cnt_o), 64'd1000);
      checkOutput("cleanErr", 64'(err_cnt_o), 64'd0);

      $display("[TB] sparse errors");
      for (int i = 1; i <= 1000; i++) applyStimulus(20, (i % 200) == 50, 1'b0);
      checkOutput("sparseErr", 64'(err_cnt_o), 64'd5);
      checkOutput("sparseBit", 64'(bit_cnt_o), 64'd2000);
      checkOutput("sparseLock", {63'b0, lock_o}, 64'd1);
      checkOutput("sparseQueue", 64'(expQ.size()), 64'd0);
      doReset();

      $display("[TB] burst inside one window");
      waitLock(20, 600);
      for (int i = 1; i <= 63; i++) applyStimulus(20, (i >= 10 && i <= 19), 1'b0);
      checkOutput("burstStillLocked", {63'b0, lock_o}, 64'd1);
      applyStimulus(20, 1'b0, 1'b0);
      checkOutput("burstDrop", {63'b0, lock_o}, 64'd0);
      checkOutput("burstLat", 64'(lat_o), 64'd21);
      checkOutput("burstBit", 64'(bit_cnt_o), 64'd64);
      checkOutput("burstErr", 64'(err_cnt_o), 64'd10);
      waitLock(20, 800);
      checkOutput("relockLat", 64'(lat_o), 64'd20);
      checkOutput("frozenBit", 64'(bit_cnt_o), 64'd64);
      checkOutput("frozenErr", 64'(err_cnt_o), 64'd10);
      doReset();

      $display("[TB] latency 63");
      waitLock(63, 800);
      checkOutput("lat63", 64'(lat_o), 64'd63);
      doReset();

      $display("[TB] latency 0");
      waitLock(0, 200);
      checkOutput("lat0", 64'(lat_o), 64'd0);
      doReset();

      $display("[TB] saturation and clear on the narrow instance");
      monEn = 1'b0;
      waitLock(20, 600);
      checkOutput("satLocked", {63'b0, satLock}, 64'd1);
      for (int i = 1; i <= 20; i++) applyStimulus(20, 1'b1, 1'b0);
      checkOutput("satErrHeld", 64'(satErr), 64'd15);
      checkOutput("satBitHeld", 64'(satBit), 64'd15);
      checkOutput("satStillLocked", {63'b0, satLock}, 64'd1);
      applyStimulus(20, 1'b1, 1'b1);
      checkOutput("clearErr", 64'(satErr), 64'd0);
      checkOutput("clearBit", 64'(satBit), 64'd0);
      applyStimulus(20, 1'b0, 1'b0);
      checkOutput("afterClearBit", 64'(satBit), 64'd1);
      checkOutput("afterClearErr", 64'(satErr), 64'd0);
      doReset();
      monEn = 1'b1;

      $display("[TB] reset while locked");
      waitLock(20, 600);
      for (int i = 1; i <= 500; i++) applyStimulus(20, 1'b0, 1'b0);
      checkOutput("preRstBit", 64'(bit_cnt_o), 64'd500);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("asyncLock", {63'b0, lock_o}, 64'd0);
      checkOutput("asyncLat", 64'(lat_o), 64'd0);
      checkOutput("asyncBit", 64'(bit_cnt_o), 64'd0);
      checkOutput("asyncErr", 64'(err_cnt_o), 64'd0);
      checkOutput("asyncPulse", {63'b0, err_pulse_o}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      srcCount = 0;
      srcHist  = '0;
      expQ.delete();
      applyStimulus(20, 1'b0, 1'b0);
      checkOutput("noLockAfterRst", {63'b0, lock_o}, 64'd0);
      waitLock(20, 600);
      checkOutput("relockAfterRst", 64'(lat_o), 64'd20);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
